// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package instr_encoder_pkg;

  // Operations accepted by the encoder.
  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAddi = 3'd2,
    OpLw   = 3'd3,
    OpSw   = 3'd4,
    OpBeq  = 3'd5,
    OpJalr = 3'd6
  } enc_op_t;

  // Rejection reasons. The value is held on err_code between errors.
  typedef enum logic [1:0] {
    ENC_ERR_NONE  = 2'd0,
    ENC_ERR_RANGE = 2'd1,
    ENC_ERR_ALIGN = 2'd2
  } enc_err_t;

  // Immediate format selectors used to dispatch field packing.
  localparam logic [1:0] IMM_TYPE_I = 2'd0;
  localparam logic [1:0] IMM_TYPE_S = 2'd1;
  localparam logic [1:0] IMM_TYPE_B = 2'd2;
  localparam logic [1:0] IMM_TYPE_R = 2'd3;

  // Major opcodes.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // Encodable immediate ranges (bytes for the branch format).
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  // Map an operation onto its instruction format.
  function automatic logic [1:0] fmt_of(enc_op_t op);
    unique case (op)
      OpAdd, OpSub:        fmt_of = IMM_TYPE_R;
      OpAddi, OpLw, OpJalr: fmt_of = IMM_TYPE_I;
      OpSw:                fmt_of = IMM_TYPE_S;
      OpBeq:               fmt_of = IMM_TYPE_B;
      default:             fmt_of = IMM_TYPE_R;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request / result bundle of the instruction encoder.
interface instr_encoder_if
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32
);
  logic                   in_valid;
  logic                   in_ready;
  enc_op_t                in_op;
  logic [4:0]             in_rd;
  logic [4:0]             in_rs1;
  logic [4:0]             in_rs2;
  logic [DATA_WIDTH-1:0]  in_imm;
  logic                   addr_load;
  logic [ADDR_WIDTH-1:0]  addr_value;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_addr;
  logic                   err_valid;
  enc_err_t               err_code;
  logic [15:0]            word_count;

  // Requester / consumer side.
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, addr_load, addr_value, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_valid, err_code, word_count
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, addr_load, addr_value, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_valid, err_code, word_count
  );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational field packer: builds the RV32I word and flags unencodable immediates.
module instr_field_packer
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  enc_op_t                op_i,
  input  logic [4:0]             rd_i,
  input  logic [4:0]             rs1_i,
  input  logic [4:0]             rs2_i,
  input  logic [DATA_WIDTH-1:0]  imm_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output enc_err_t               err_o
);

  logic signed [DATA_WIDTH-1:0] imm_s;
  logic                         in12, in13, op_known;
  logic [6:0]                   opc, f7;
  logic [2:0]                   f3;
  logic [31:0]                  word;

  assign imm_s = $signed(imm_i);
  assign in12  = (imm_s >= $signed(DATA_WIDTH'(IMM12_MIN))) &&
                 (imm_s <= $signed(DATA_WIDTH'(IMM12_MAX)));
  assign in13  = (imm_s >= $signed(DATA_WIDTH'(IMM13_MIN))) &&
                 (imm_s <= $signed(DATA_WIDTH'(IMM13_MAX)));

  // Per-operation opcode / funct fields.
  always_comb begin
    opc      = '0;
    f3       = '0;
    f7       = F7_ADD;
    op_known = 1'b1;
    unique case (op_i)
      OpAdd:   begin opc = OPC_OP;     f3 = F3_ADD;              end
      OpSub:   begin opc = OPC_OP;     f3 = F3_ADD; f7 = F7_SUB; end
      OpAddi:  begin opc = OPC_OP_IMM; f3 = F3_ADD;              end
      OpLw:    begin opc = OPC_LOAD;   f3 = F3_WORD;             end
      OpJalr:  begin opc = OPC_JALR;   f3 = F3_ADD;              end
      OpSw:    begin opc = OPC_STORE;  f3 = F3_WORD;             end
      OpBeq:   begin opc = OPC_BRANCH; f3 = F3_BEQ;              end
      default: op_known = 1'b0;
    endcase
  end

  // Format dispatch and range / alignment checks; RANGE wins over ALIGN.
  always_comb begin
    word  = '0;
    err_o = ENC_ERR_NONE;
    unique case (fmt_of(op_i))
      IMM_TYPE_R: word = {f7, rs2_i, rs1_i, f3, rd_i, opc};
      IMM_TYPE_I: begin
        word = {imm_i[11:0], rs1_i, f3, rd_i, opc};
        if (!in12) err_o = ENC_ERR_RANGE;
      end
      IMM_TYPE_S: begin
        word = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opc};
        if (!in12) err_o = ENC_ERR_RANGE;
      end
      IMM_TYPE_B: begin
        word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], opc};
        if (!in13)         err_o = ENC_ERR_RANGE;
        else if (imm_i[0]) err_o = ENC_ERR_ALIGN;
      end
      default: word = '0;
    endcase
    // Unsupported op codes produce an all-zero (illegal) word.
    if (!op_known) word = '0;
  end

  assign instr_o = INSTR_WIDTH'(word);

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: handshake, output register, address and word counters.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic               clk,
  input logic               rst,
  instr_encoder_if.slave    bus
);

  logic [INSTR_WIDTH-1:0] packed_instr;
  enc_err_t               packed_err;

  instr_field_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_packer (
    .op_i   (bus.in_op),
    .rd_i   (bus.in_rd),
    .rs1_i  (bus.in_rs1),
    .rs2_i  (bus.in_rs2),
    .imm_i  (bus.in_imm),
    .instr_o(packed_instr),
    .err_o  (packed_err)
  );

  logic                   out_valid_q, out_valid_d;
  logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
  // Address of the held word, or of the next word while the register is empty.
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic                   err_valid_q, err_valid_d;
  enc_err_t               err_code_q, err_code_d;
  logic [15:0]            word_count_q, word_count_d;
  logic                   in_ready, accept, load_word, xfer;

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign load_word = accept && (packed_err == ENC_ERR_NONE);
  assign xfer      = out_valid_q && bus.out_ready;

  // Next-state for output register, address counter, error and statistics.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    word_count_d = word_count_q;

    if (xfer) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + ADDR_WIDTH'(4);
    end else if (!out_valid_q && bus.addr_load) begin
      out_addr_d = {bus.addr_value[ADDR_WIDTH-1:2], 2'b00};
    end

    if (load_word) begin
      out_valid_d = 1'b1;
      out_instr_d = packed_instr;
      if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
    end

    if (accept && (packed_err != ENC_ERR_NONE)) begin
      err_valid_d = 1'b1;
      err_code_d  = packed_err;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= BASE_ADDR;
      err_valid_q  <= 1'b0;
      err_code_q   <= ENC_ERR_NONE;
      word_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_encoder_if #(.DATA_WIDTH(32), .INSTR_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_encoder #(
    .DATA_WIDTH (32),
    .INSTR_WIDTH(32),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input enc_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_op  = op;
    bus.in_rd  = rd;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_imm = imm;
  endtask

  task automatic issue(input enc_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    drive(op, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.addr_load = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_word(input string tag, input logic [31:0] instr, input logic [31:0] addr);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_instr"}, bus.out_instr, instr);
    check_eq({tag, "_addr"}, bus.out_addr, addr);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = OpAdd;
    bus.in_rd      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_imm     = '0;
    bus.addr_load  = 1'b0;
    bus.addr_value = '0;
    bus.out_ready  = 1'b1;
    do_reset();

    // Reset state
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_instr", bus.out_instr, 32'h0);
    check_eq("rst_out_addr", bus.out_addr, 32'h0);
    check_eq("rst_err_valid", 32'(bus.err_valid), 32'd0);
    check_eq("rst_err_code", 32'(bus.err_code), 32'(ENC_ERR_NONE));
    check_eq("rst_word_count", 32'(bus.word_count), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADDI x5, x0, -1
    issue(OpAddi, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    check_word("addi_m1", 32'hFFF0_0293, 32'h0);
    check_eq("addi_m1_count", 32'(bus.word_count), 32'd1);

    // SW then BEQ back-to-back
    do_reset();
    issue(OpSw, 5'd0, 5'd2, 5'd6, 32'd8);
    check_word("sw", 32'h0061_2423, 32'h0);
    issue(OpBeq, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    check_word("beq_m4", 32'hFE20_8EE3, 32'h4);
    tick();
    check_eq("b2b_drained", 32'(bus.out_valid), 32'd0);
    check_eq("b2b_count", 32'(bus.word_count), 32'd2);

    // Rejections: range, range-over-align, align, then a good word
    do_reset();
    issue(OpAddi, 5'd1, 5'd0, 5'd0, 32'd2048);
    check_eq("rng_err_valid", 32'(bus.err_valid), 32'd1);
    check_eq("rng_err_code", 32'(bus.err_code), 32'(ENC_ERR_RANGE));
    check_eq("rng_no_out", 32'(bus.out_valid), 32'd0);
    issue(OpBeq, 5'd0, 5'd1, 5'd2, 32'd4095);
    check_eq("rng_prio_valid", 32'(bus.err_valid), 32'd1);
    check_eq("rng_prio_code", 32'(bus.err_code), 32'(ENC_ERR_RANGE));
    issue(OpBeq, 5'd0, 5'd1, 5'd2, 32'd3);
    check_eq("aln_err_valid", 32'(bus.err_valid), 32'd1);
    check_eq("aln_err_code", 32'(bus.err_code), 32'(ENC_ERR_ALIGN));
    check_eq("aln_no_out", 32'(bus.out_valid), 32'd0);
    issue(OpAddi, 5'd1, 5'd0, 5'd0, 32'd2047);
    check_word("addi_max", 32'h7FF0_0093, 32'h0);
    check_eq("err_pulse_end", 32'(bus.err_valid), 32'd0);
    check_eq("err_code_held", 32'(bus.err_code), 32'(ENC_ERR_ALIGN));
    check_eq("err_count", 32'(bus.word_count), 32'd1);

    // Backpressure: ADD held, SUB waits, then both leave on consecutive cycles
    do_reset();
    bus.out_ready = 1'b0;
    issue(OpAdd, 5'd3, 5'd1, 5'd2, 32'h0);
    check_word("add", 32'h0020_81B3, 32'h0);
    drive(OpSub, 5'd3, 5'd1, 5'd2, 32'h0);
    bus.in_valid = 1'b1;
    check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_instr", bus.out_instr, 32'h0020_81B3);
      check_eq("stall_addr", bus.out_addr, 32'h0);
      check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check_eq("stall_count", 32'(bus.word_count), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check_word("sub", 32'h4020_81B3, 32'h4);
    tick();
    check_eq("stall_drained", 32'(bus.out_valid), 32'd0);
    check_eq("stall_count2", 32'(bus.word_count), 32'd2);

    // Address load while idle, wrap, and ignored load while busy
    do_reset();
    bus.addr_load  = 1'b1;
    bus.addr_value = 32'hFFFF_FFFE;
    tick();
    bus.addr_load = 1'b0;
    issue(OpLw, 5'd7, 5'd2, 5'd0, 32'd16);
    check_word("lw", 32'h0101_2383, 32'hFFFF_FFFC);
    issue(OpJalr, 5'd1, 5'd1, 5'd0, 32'd0);
    check_word("jalr_wrap", 32'h0000_80E7, 32'h0);
    bus.out_ready  = 1'b0;
    bus.addr_load  = 1'b1;
    bus.addr_value = 32'h0000_0100;
    tick();
    bus.addr_load = 1'b0;
    check_word("load_ignored", 32'h0000_80E7, 32'h0);
    bus.out_ready = 1'b1;
    issue(OpBeq, 5'd0, 5'd0, 5'd0, 32'd4094);
    check_word("beq_max", 32'h7E00_0FE3, 32'h4);
    issue(OpBeq, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000);
    check_word("beq_min", 32'h8000_0063, 32'h8);

    // Reset while a word is held: discarded immediately
    bus.out_ready = 1'b0;
    tick();
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("async_rst_instr", bus.out_instr, 32'h0);
    check_eq("async_rst_addr", bus.out_addr, 32'h0);
    check_eq("async_rst_count", 32'(bus.word_count), 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_eq("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("post_rst_addr", bus.out_addr, 32'h0);

    // Load and accept in the same cycle; unused fields ignored
    do_reset();
    bus.addr_load  = 1'b1;
    bus.addr_value = 32'h0000_0043;
    issue(OpAdd, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
    bus.addr_load = 1'b0;
    check_word("add_loaded", 32'h0020_81B3, 32'h40);
    issue(OpSw, 5'd31, 5'd2, 5'd6, 32'd8);
    check_word("sw_rd_ignored", 32'h0061_2423, 32'h44);
    issue(OpAddi, 5'd1, 5'd0, 5'd31, 32'hFFFF_F800);
    check_word("addi_min", 32'h8000_0093, 32'h48);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
